join_n: RTL and testbench

JOIN_N -- requirements
Module: join_n

---
 rtl/join_n.sv | 131 +++++++++++++
 tb/tb_join_n.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/join_n.sv
// N-way four-phase handshake join: waits for every enabled request, raises one
// joined request, fans the joined acknowledge back and counts completed cycles.
module join_n #(
  parameter int unsigned N    = 2,
  parameter int unsigned W    = 8,
  parameter int unsigned CW   = 16,
  parameter logic        Rpol = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    r_i,
  output logic [N-1:0]    a_i,
  input  logic [N*W-1:0]  d_i,
  input  logic [N-1:0]    en_i,
  output logic            r_o,
  input  logic            a_o,
  output logic [N*W-1:0]  d_o,
  output logic            err,
  output logic [CW-1:0]   cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t         r_state, w_state_nxt;
  logic           r_req, w_req_nxt;
  logic [N-1:0]   r_ack, w_ack_nxt;
  logic [N-1:0]   r_mask, w_mask_nxt;
  logic [N-1:0]   r_fallen, w_fallen_nxt;
  logic [N*W-1:0] r_data, w_data_nxt;
  logic           r_err, w_err_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;

  logic           w_rst;
  logic           w_fire;
  logic [N-1:0]   w_act_r;
  logic [N*W-1:0] w_din_masked;

  assign w_rst   = (rst == Rpol);
  assign w_act_r = r_i & r_mask;
  assign w_fire  = (|en_i) && ((r_i & en_i) == en_i) && !a_o;

  // Disabled lanes capture zero so their d_i never reaches d_o.
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign w_din_masked[k*W +: W] = en_i[k] ? d_i[k*W +: W] : '0;
  end

  // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_ack_nxt    = r_ack;
    w_mask_nxt   = r_mask;
    w_fallen_nxt = r_fallen;
    w_data_nxt   = r_data;
    w_err_nxt    = r_err;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (a_o) begin
          w_err_nxt = 1'b1;
        end else if (w_fire) begin
          w_mask_nxt  = en_i;
          w_data_nxt  = w_din_masked;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_act_r != r_mask) w_err_nxt = 1'b1;
        if (a_o) begin
          w_ack_nxt    = r_mask;
          w_fallen_nxt = '0;
          w_state_nxt  = S_HOLD;
        end
      end
      S_HOLD: begin
        // A channel seen low earlier in HOLD must not rise again.
        w_fallen_nxt = r_fallen | (r_mask & ~r_i);
        if (|(r_fallen & r_i & r_mask)) w_err_nxt = 1'b1;
        if (w_act_r == '0) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_REL;
        end
      end
      S_REL: begin
        if (!a_o) begin
          w_ack_nxt   = '0;
          w_cnt_nxt   = r_cnt + CW'(1);
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_ack    <= '0;
      r_mask   <= '0;
      r_fallen <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_ack    <= w_ack_nxt;
      r_mask   <= w_mask_nxt;
      r_fallen <= w_fallen_nxt;
      r_data   <= w_data_nxt;
      r_err    <= w_err_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign r_o = r_req;
  assign a_i = r_ack;
  assign d_o = r_data;
  assign err = r_err;
  assign cnt = r_cnt;

endmodule

// File: tb/tb_join_n.sv
// Self-checking bench for join_n: a 2-channel table-driven run plus hand
// sequences on a 3-channel, 2-bit-counter instance.
module tb_join_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-channel instance
  logic        rst_a;
  logic [1:0]  r_i_a, a_i_a, en_i_a;
  logic [15:0] d_i_a, d_o_a;
  logic        r_o_a, a_o_a, err_a;
  logic [15:0] cnt_a;

  // 3-channel instance with a wrapping 2-bit counter
  logic        rst_b;
  logic [2:0]  r_i_b, a_i_b, en_i_b;
  logic [23:0] d_i_b, d_o_b;
  logic        r_o_b, a_o_b, err_b;
  logic [1:0]  cnt_b;

  join_n #(.N(2), .W(8), .CW(16), .Rpol(1'b1)) u_dut_a (
    .clk(clk), .rst(rst_a), .r_i(r_i_a), .a_i(a_i_a), .d_i(d_i_a), .en_i(en_i_a),
    .r_o(r_o_a), .a_o(a_o_a), .d_o(d_o_a), .err(err_a), .cnt(cnt_a)
  );

  join_n #(.N(3), .W(8), .CW(2), .Rpol(1'b1)) u_dut_b (
    .clk(clk), .rst(rst_b), .r_i(r_i_b), .a_i(a_i_b), .d_i(d_i_b), .en_i(en_i_b),
    .r_o(r_o_b), .a_o(a_o_b), .d_o(d_o_b), .err(err_b), .cnt(cnt_b)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  en;
    logic [1:0]  r;
    logic [15:0] d;
    logic        a_o;
    logic        exp_r_o;
    logic [1:0]  exp_a_i;
    logic [15:0] exp_d_o;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic        r_o;
    logic [2:0]  a_i;
    logic [23:0] d_o;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] en, input logic [1:0] r,
                     input logic [15:0] d, input logic a_o, input logic e_r_o,
                     input logic [1:0] e_a_i, input logic [15:0] e_d_o,
                     input logic e_err, input logic [15:0] e_cnt);
    vec_t v;
    v = '{rst, en, r, d, a_o, e_r_o, e_a_i, e_d_o, e_err, e_cnt};
    tbl.push_back(v);
  endtask

  task automatic compare(input string tag, input logic r_o, input logic [2:0] a_i,
                         input logic [23:0] d_o, input logic err, input logic [15:0] cnt);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".r_o"}, 32'(r_o), 32'(e.r_o));
      check({tag, ".a_i"}, 32'(a_i), 32'(e.a_i));
      check({tag, ".d_o"}, 32'(d_o), 32'(e.d_o));
      check({tag, ".err"}, 32'(err), 32'(e.err));
      check({tag, ".cnt"}, 32'(cnt), 32'(e.cnt));
    end
  endtask

  task automatic step_b(input string tag, input logic rst, input logic [2:0] en,
                        input logic [2:0] r, input logic [23:0] d, input logic a_o,
                        input logic e_r_o, input logic [2:0] e_a_i, input logic [23:0] e_d_o,
                        input logic e_err, input logic [1:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst_b = rst; en_i_b = en; r_i_b = r; d_i_b = d; a_o_b = a_o;
    e = '{e_r_o, e_a_i, e_d_o, e_err, 16'(e_cnt)};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag, r_o_b, a_i_b, d_o_b, err_b, 16'(cnt_b));
  endtask

  initial begin
    logic [1:0]  wrap_seq [4];
    logic [23:0] d_rand, d_junk;
    exp_t        e;

    rst_a = 1'b1; r_i_a = '0; en_i_a = '0; d_i_a = '0; a_o_a = 1'b0;
    rst_b = 1'b1; r_i_b = '0; en_i_b = '0; d_i_b = '0; a_o_b = 1'b0;

    //   rst en    r     d        a_o  r_o a_i   d_o      err cnt
    add(1, 2'b11, 2'b11, 16'hA55A, 0,  0, 2'b00, 16'h0000, 0, 0);  // reset wins over fire
    add(0, 2'b11, 2'b11, 16'hA55A, 0,  1, 2'b00, 16'hA55A, 0, 0);  // fires first cycle after reset
    add(0, 2'b11, 2'b11, 16'h1234, 0,  1, 2'b00, 16'hA55A, 0, 0);
    add(0, 2'b11, 2'b11, 16'h1234, 1,  1, 2'b11, 16'hA55A, 0, 0);
    add(0, 2'b11, 2'b00, 16'h1234, 1,  0, 2'b11, 16'hA55A, 0, 0);
    add(0, 2'b11, 2'b00, 16'h1234, 0,  0, 2'b00, 16'hA55A, 0, 1);
    for (int i = 0; i < 5; i++)
      add(0, 2'b11, 2'b01, 16'h00C3, 0, 0, 2'b00, 16'hA55A, 0, 1);  // staggered rise
    add(0, 2'b11, 2'b11, 16'h3C3C, 0,  1, 2'b00, 16'h3C3C, 0, 1);
    add(0, 2'b11, 2'b10, 16'hFFFF, 0,  1, 2'b00, 16'h3C3C, 1, 1);  // drop in REQ
    add(0, 2'b11, 2'b11, 16'hFFFF, 1,  1, 2'b11, 16'h3C3C, 1, 1);
    add(0, 2'b11, 2'b00, 16'hFFFF, 1,  0, 2'b11, 16'h3C3C, 1, 1);
    add(0, 2'b11, 2'b00, 16'hFFFF, 0,  0, 2'b00, 16'h3C3C, 1, 2);  // err stays sticky
    add(1, 2'b11, 2'b11, 16'h5555, 0,  0, 2'b00, 16'h0000, 0, 0);
    add(0, 2'b11, 2'b11, 16'h5555, 1,  0, 2'b00, 16'h0000, 1, 0);  // a_o high in IDLE
    add(0, 2'b11, 2'b11, 16'h5555, 0,  1, 2'b00, 16'h5555, 1, 0);
    add(0, 2'b11, 2'b11, 16'h5555, 1,  1, 2'b11, 16'h5555, 1, 0);
    add(1, 2'b11, 2'b11, 16'h5555, 1,  0, 2'b00, 16'h0000, 0, 0);  // reset in HOLD
    add(0, 2'b11, 2'b11, 16'h0F0F, 0,  1, 2'b00, 16'h0F0F, 0, 0);
    add(0, 2'b01, 2'b11, 16'h0F0F, 1,  1, 2'b11, 16'h0F0F, 0, 0);  // en change ignored
    add(0, 2'b01, 2'b01, 16'h0F0F, 1,  1, 2'b11, 16'h0F0F, 0, 0);
    add(0, 2'b01, 2'b11, 16'h0F0F, 1,  1, 2'b11, 16'h0F0F, 1, 0);  // re-rise in HOLD
    add(0, 2'b01, 2'b00, 16'h0F0F, 1,  0, 2'b11, 16'h0F0F, 1, 0);
    add(0, 2'b01, 2'b00, 16'h0F0F, 0,  0, 2'b00, 16'h0F0F, 1, 1);
    add(0, 2'b00, 2'b11, 16'hAAAA, 0,  0, 2'b00, 16'h0F0F, 1, 1);  // empty join never fires

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_a = tbl[i].rst; en_i_a = tbl[i].en; r_i_a = tbl[i].r;
      d_i_a = tbl[i].d;   a_o_a = tbl[i].a_o;
      e = '{tbl[i].exp_r_o, {1'b0, tbl[i].exp_a_i}, {8'h00, tbl[i].exp_d_o},
            tbl[i].exp_err, tbl[i].exp_cnt};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      compare($sformatf("a%0d", i), r_o_a, {1'b0, a_i_a}, {8'h00, d_o_a}, err_a, cnt_a);
    end

    // Channel 1 disabled: its request and data are ignored throughout.
    step_b("b_rst",  1, 3'b101, 3'b000, 24'h000000, 0, 0, 3'b000, 24'h000000, 0, 0);
    step_b("b_fire", 0, 3'b101, 3'b101, 24'h332211, 0, 1, 3'b000, 24'h330011, 0, 0);
    step_b("b_hold", 0, 3'b101, 3'b111, 24'h33EE11, 1, 1, 3'b101, 24'h330011, 0, 0);
    step_b("b_rel",  0, 3'b010, 3'b010, 24'h445566, 1, 0, 3'b101, 24'h330011, 0, 0);
    step_b("b_idle", 0, 3'b101, 3'b000, 24'h778899, 0, 0, 3'b000, 24'h330011, 0, 1);

    // Four more minimum-length cycles: counter walks 2,3,0,1.
    wrap_seq[0] = 2'd2; wrap_seq[1] = 2'd3; wrap_seq[2] = 2'd0; wrap_seq[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      d_rand = 24'($urandom);
      d_junk = 24'($urandom);
      step_b($sformatf("w%0d_req", k),  0, 3'b111, 3'b111, d_rand, 0,
             1, 3'b000, d_rand, 0, wrap_seq[(k + 3) % 4]);
      step_b($sformatf("w%0d_hold", k), 0, 3'b111, 3'b111, d_junk, 1,
             1, 3'b111, d_rand, 0, wrap_seq[(k + 3) % 4]);
      step_b($sformatf("w%0d_rel", k),  0, 3'b111, 3'b000, d_junk, 1,
             0, 3'b111, d_rand, 0, wrap_seq[(k + 3) % 4]);
      step_b($sformatf("w%0d_idle", k), 0, 3'b111, 3'b000, d_junk, 0,
             0, 3'b000, d_rand, 0, wrap_seq[k]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
